chipmunk_neg2pos_stream: RTL and testbench

Half-cycle retiming stream stage with valid/ready handshakes on both sides. The input side is sampled on the falling edge of `clock`, so it receives data launched by rising-edge logic half a cycle earlier. The output side is a rising-edge, 2-entry buffered stream. It returns falling-edge-domain traffic, such as the output of our negedge init registers, to the rising-edge pipeline at full throughput.

---
 rtl/chipmunk_neg2pos_stream_pkg.sv | 20 ++
 rtl/chipmunk_neg2pos_fifo2.sv | 72 +++++++
 rtl/chipmunk_neg2pos_stream.sv | 71 +++++++
 tb/tb_chipmunk_neg2pos_stream.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/chipmunk_neg2pos_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : chipmunk_neg2pos_stream_pkg
//  Brief    : Shared constants and helpers for the negedge-to-posedge stream
//             retiming stage.
//  Revision : 1.0 - initial release
// ============================================================================
package chipmunk_neg2pos_stream_pkg;

    // Depth of the rising-edge output buffer and the width of its occupancy count.
    localparam int C_FIFO_DEPTH = 2;
    localparam int C_CNT_W      = 2;

    // Advance a 1-bit ring pointer; wraps 1 -> 0 for the 2-entry buffer.
    function automatic logic ptr_next(input logic ptr);
        return ~ptr;
    endfunction

endpackage : chipmunk_neg2pos_stream_pkg
`default_nettype wire

// File: rtl/chipmunk_neg2pos_fifo2.sv
`default_nettype none
// ============================================================================
//  Module   : chipmunk_neg2pos_fifo2
//  Brief    : Rising-edge 2-entry FIFO. Decides push acceptance itself so a
//             push into a full buffer is allowed when the head pops on the
//             same edge.
//  Revision : 1.0 - initial release
// ============================================================================
module chipmunk_neg2pos_fifo2
    import chipmunk_neg2pos_stream_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push_req,
    input  logic [WIDTH-1:0] push_data,
    output logic             push_ack,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0]   r_mem [0:C_FIFO_DEPTH-1];
    logic               r_rd_ptr;
    logic               r_wr_ptr;
    logic [C_CNT_W-1:0] r_count;
    logic               w_pop;

    // Head handshake and push acceptance; a pop frees the slot for a push on the same edge.
    always_comb begin
        out_valid = (r_count != '0);
        w_pop     = out_valid && out_ready;
        push_ack  = push_req && ((r_count < C_CNT_W'(C_FIFO_DEPTH)) || w_pop);
        out_data  = r_mem[r_rd_ptr];
    end

    // Storage array: written on accepted pushes, preset to INIT on reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < C_FIFO_DEPTH; i++) begin
                r_mem[i] <= INIT;
            end
        end else if (push_ack) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (push_ack) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({push_ack, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : chipmunk_neg2pos_fifo2
`default_nettype wire

// File: rtl/chipmunk_neg2pos_stream.sv
`default_nettype none
// ============================================================================
//  Module   : chipmunk_neg2pos_stream
//  Brief    : Half-cycle retiming stream stage. Input captured on the falling
//             edge, handed to a rising-edge 2-entry buffer via a toggle pair.
//  Revision : 1.0 - initial release
// ============================================================================
module chipmunk_neg2pos_stream
    import chipmunk_neg2pos_stream_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] r_cap_data;
    logic             r_cap_tog;
    logic             r_ack_tog;
    logic             w_pending;
    logic             w_push_ack;

    // A capture is outstanding while the two toggles disagree; in_ready comes from flops only.
    always_comb begin
        w_pending = r_cap_tog ^ r_ack_tog;
        in_ready  = !w_pending;
    end

    // Falling-edge capture of data launched by rising-edge producers.
    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cap_data <= INIT;
            r_cap_tog  <= 1'b0;
        end else if (in_valid && in_ready) begin
            r_cap_data <= in_data;
            r_cap_tog  <= ~r_cap_tog;
        end
    end

    // Rising-edge acknowledge: flipping closes the pending window when the buffer takes the item.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ack_tog <= 1'b0;
        end else if (w_push_ack) begin
            r_ack_tog <= ~r_ack_tog;
        end
    end

    chipmunk_neg2pos_fifo2 #(
        .WIDTH (WIDTH),
        .INIT  (INIT)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push_req  (w_pending),
        .push_data (r_cap_data),
        .push_ack  (w_push_ack),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

endmodule : chipmunk_neg2pos_stream
`default_nettype wire

// File: tb/tb_chipmunk_neg2pos_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_chipmunk_neg2pos_stream
//  Brief    : Self-checking bench for the negedge-to-posedge stream stage.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_chipmunk_neg2pos_stream;

    localparam logic [7:0] C_INIT = 8'hA5;

    logic       clock;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;

    int checks = 0;
    int errors = 0;

    chipmunk_neg2pos_stream #(
        .WIDTH (8),
        .INIT  (C_INIT)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: one capture slot plus an ordered queue of at most two buffered items.
    logic [7:0] m_q[$];
    logic       m_pend;
    logic [7:0] m_cap;
    logic       m_acc;

    // Sampled DUT values and model expectations for the last cycle.
    logic       s_ir, s_ov;
    logic [7:0] s_od;
    logic       e_ir, e_ov;
    logic [7:0] e_od;

    task automatic model_reset();
        m_q.delete();
        m_pend = 1'b0;
        m_cap  = C_INIT;
        m_acc  = 1'b0;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One clock cycle, entered and left 1 time unit after a rising edge.
    task automatic run_cycle(input logic v, input logic [7:0] d, input logic r);
        logic pop;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #3;
        s_ir = in_ready;
        e_ir = !m_pend;
        @(negedge clock);
        m_acc = v && !m_pend;
        if (m_acc) begin
            m_pend = 1'b1;
            m_cap  = d;
        end
        @(posedge clock);
        pop = (m_q.size() != 0) && r;
        if (pop) void'(m_q.pop_front());
        if (m_pend && m_q.size() < 2) begin
            m_q.push_back(m_cap);
            m_pend = 1'b0;
        end
        #1;
        s_ov = out_valid;
        s_od = out_data;
        e_ov = (m_q.size() != 0);
        e_od = e_ov ? m_q[0] : 8'h00;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_in_ready"}, {7'd0, s_ir}, {7'd0, e_ir});
        check({tag, "_out_valid"}, {7'd0, s_ov}, {7'd0, e_ov});
        if (e_ov) check({tag, "_out_data"}, s_od, e_od);
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       r;
        logic       exp_ir;
        logic       exp_ov;
        logic [7:0] exp_od;
    } vec_t;

    vec_t tbl [11];

    initial begin
        // single item, then 1,2,3,4 under backpressure, then drain
        tbl[0]  = '{1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 8'h3C};
        tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[2]  = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 8'h01};
        tbl[3]  = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 8'h01};
        tbl[4]  = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 8'h01};
        tbl[5]  = '{1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 8'h01};
        tbl[6]  = '{1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 8'h01};
        tbl[7]  = '{1'b1, 8'h04, 1'b1, 1'b0, 1'b1, 8'h02};
        tbl[8]  = '{1'b1, 8'h04, 1'b1, 1'b1, 1'b1, 8'h03};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h04};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        model_reset();

        // Reset values while held in reset
        repeat (2) @(posedge clock);
        #1;
        check("reset_in_ready", {7'd0, in_ready}, 8'h01);
        check("reset_out_valid", {7'd0, out_valid}, 8'h00);
        check("reset_out_data", out_data, C_INIT);
        reset_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 11; i++) begin
            run_cycle(tbl[i].v, tbl[i].d, tbl[i].r);
            check($sformatf("tbl%0d_in_ready", i), {7'd0, s_ir}, {7'd0, tbl[i].exp_ir});
            check($sformatf("tbl%0d_out_valid", i), {7'd0, s_ov}, {7'd0, tbl[i].exp_ov});
            if (tbl[i].exp_ov) check($sformatf("tbl%0d_out_data", i), s_od, tbl[i].exp_od);
        end

        // Streaming 0..15 at full rate
        for (int i = 0; i < 16; i++) begin
            run_cycle(1'b1, 8'(i), 1'b1);
            check($sformatf("stream%0d_in_ready", i), {7'd0, s_ir}, 8'h01);
            check($sformatf("stream%0d_out_valid", i), {7'd0, s_ov}, 8'h01);
            check($sformatf("stream%0d_out_data", i), s_od, 8'(i));
        end
        run_cycle(1'b0, 8'h00, 1'b1);
        check_model("stream_drain");

        // Fill to count 2 plus pending, then alternate pop+push / refill for 10 iterations
        run_cycle(1'b1, 8'h40, 1'b0);
        run_cycle(1'b1, 8'h41, 1'b0);
        run_cycle(1'b1, 8'h42, 1'b0);
        check_model("full_fill");
        for (int k = 0; k < 10; k++) begin
            run_cycle(1'b0, 8'h00, 1'b1);
            check_model($sformatf("wrap%0d_poppush", k));
            check($sformatf("wrap%0d_head", k), s_od, 8'(8'h41 + k));
            run_cycle(1'b1, 8'(8'h43 + k), 1'b0);
            check_model($sformatf("wrap%0d_refill", k));
            run_cycle(1'b0, 8'h00, 1'b0);
            check($sformatf("wrap%0d_still_full", k), {7'd0, s_ir}, 8'h00);
        end

        // Reset asserted mid-cycle while three items are held
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("midreset_in_ready", {7'd0, in_ready}, 8'h01);
        check("midreset_out_valid", {7'd0, out_valid}, 8'h00);
        check("midreset_out_data", out_data, C_INIT);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        run_cycle(1'b0, 8'h00, 1'b0);
        check("postreset_out_valid", {7'd0, s_ov}, 8'h00);
        run_cycle(1'b1, 8'h77, 1'b1);
        check("postreset_first_valid", {7'd0, s_ov}, 8'h01);
        check("postreset_first_data", s_od, 8'h77);
        run_cycle(1'b0, 8'h00, 1'b1);
        check_model("postreset_drain");

        // Randomized traffic against the model, honouring the hold-until-accepted rule
        begin
            logic       v;
            logic [7:0] d;
            logic       holding;
            holding = 1'b0;
            v = 1'b0;
            d = 8'h00;
            for (int n = 0; n < 400; n++) begin
                if (holding) begin
                    if ($urandom_range(3) == 0) v = 1'b0;
                    else v = 1'b1;
                end else begin
                    v = ($urandom_range(3) != 0);
                    d = 8'($urandom);
                end
                run_cycle(v, d, ($urandom_range(2) != 0));
                check_model($sformatf("rand%0d", n));
                if (v && !m_acc) holding = 1'b1;
                else if (!v && holding) holding = ($urandom_range(1) == 0);
                else holding = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case the sequence above stalls.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_chipmunk_neg2pos_stream
`default_nettype wire
